// File: rtl/config_chain_segment_if.sv
// Chain-side signal bundle for one config_chain_segment.
//   master : driven by the bitstream loader (or previous tile logic)
//   slave  : the segment itself
// Signals:
//   enable     shift strobe
//   data_in    LANES-bit chain input
//   data_out   LANES-bit chain output (top of the shift register)
//   commit     copy shift register into shadow register
//   capture    copy shadow register into shift register (readback)
//   config_out active configuration (shadow register)
//   full       a complete frame has been shifted in
interface config_chain_segment_if #(
  parameter int unsigned CONFIG_WIDTH = 4,
  parameter int unsigned LANES        = 1
);
  logic                    enable;
  logic [LANES-1:0]        data_in;
  logic [LANES-1:0]        data_out;
  logic                    commit;
  logic                    capture;
  logic [CONFIG_WIDTH-1:0] config_out;
  logic                    full;

  modport master (
    output enable, data_in, commit, capture,
    input  data_out, config_out, full
  );

  modport slave (
    input  enable, data_in, commit, capture,
    output data_out, config_out, full
  );
endinterface

// File: rtl/config_chain_segment.sv
// Configuration-chain segment for one kfpga tile.
// A LANES-wide serial shift register of CONFIG_WIDTH bits feeds a shadow register, so the
// tile's active configuration only changes on a commit strobe. A capture strobe reloads
// the shift register from the shadow register for readback, and a saturating frame
// counter flags when a full frame (CONFIG_WIDTH/LANES shifts) has been loaded.
// Ports:
//   clock  : rising-edge clock
//   nreset : synchronous active-low reset, overrides everything
//   bus    : chain signals (enable, data_in, data_out, commit, capture, config_out, full)
// All outputs are decoded directly from registers; no input-to-output combinational path.
module config_chain_segment #(
  parameter int unsigned CONFIG_WIDTH = 4,
  parameter int unsigned LANES        = 1
) (
  input logic                  clock,
  input logic                  nreset,
  config_chain_segment_if.slave bus
);

  localparam int unsigned DEPTH = CONFIG_WIDTH / LANES;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic [CONFIG_WIDTH-1:0] sr_q, sr_d;
  logic [CONFIG_WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CONFIG_WIDTH-1:0] sr_shifted;

  // A single-group chain has nothing to shift along; it simply loads data_in.
  if (LANES == CONFIG_WIDTH) begin : g_single_group
    assign sr_shifted = bus.data_in;
  end else begin : g_multi_group
    assign sr_shifted = {sr_q[CONFIG_WIDTH-LANES-1:0], bus.data_in};
  end

  always_comb begin
    sr_d  = sr_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;

    if (bus.capture) begin
      sr_d = sh_q;
    end else if (bus.enable) begin
      sr_d = sr_shifted;
    end

    // Uses the pre-edge sr_q, so commit+capture swaps and commit+enable commits pre-shift data.
    if (bus.commit) begin
      sh_d = sr_q;
    end

    if (bus.capture) begin
      cnt_d = '0;
    end else if (bus.commit && bus.enable) begin
      cnt_d = CntW'(1);
    end else if (bus.commit) begin
      cnt_d = '0;
    end else if (bus.enable && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      sr_q  <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.data_out   = sr_q[CONFIG_WIDTH-1 -: LANES];
  assign bus.config_out = sh_q;
  assign bus.full       = (cnt_q == CntMax);

endmodule

// File: tb/tb_config_chain_segment.sv
// Directed self-checking bench for config_chain_segment with CONFIG_WIDTH=8, LANES=2.
module tb_config_chain_segment;

  localparam int unsigned CW = 8;
  localparam int unsigned LN = 2;

  logic clock;
  logic nreset;

  int unsigned n_checks;
  int unsigned n_fails;

  config_chain_segment_if #(.CONFIG_WIDTH(CW), .LANES(LN)) bus ();

  config_chain_segment #(.CONFIG_WIDTH(CW), .LANES(LN)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, then sample 1 time unit after it.
  task automatic step(input logic en, input logic [1:0] din, input logic com, input logic cap);
    bus.enable  = en;
    bus.data_in = din;
    bus.commit  = com;
    bus.capture = cap;
    @(posedge clock);
    #1;
    bus.enable  = 1'b0;
    bus.data_in = 2'b00;
    bus.commit  = 1'b0;
    bus.capture = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] d, input logic [7:0] c,
                            input logic f);
    check({tag, ".data_out"},   32'(bus.data_out),   32'(d));
    check({tag, ".config_out"}, 32'(bus.config_out), 32'(c));
    check({tag, ".full"},       32'(bus.full),       32'(f));
  endtask

  initial begin
    logic [1:0] frame [4];
    logic [1:0] expd  [4];
    n_checks = 0;
    n_fails  = 0;
    frame = '{2'b11, 2'b10, 2'b01, 2'b00};
    expd  = '{2'b10, 2'b01, 2'b00, 2'b00};

    // 1. Reset with random inputs.
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end
    check_outs("reset", 2'b00, 8'h00, 1'b0);
    check("reset.sr", 32'(dut.sr_q), 32'h00);
    nreset = 1'b1;

    // 2. Frame load.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, frame[i], 1'b0, 1'b0);
      if (i == 2) check("load.full_early", 32'(bus.full), 32'h0);
    end
    check("load.sr", 32'(dut.sr_q), 32'hE4);
    check_outs("load", 2'b11, 8'h00, 1'b1);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    check_outs("commit", 2'b11, 8'hE4, 1'b0);

    // 3. Chaining: shifted-out groups appear on data_out in load order.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      check($sformatf("chain.dout%0d", i), 32'(bus.data_out), 32'(expd[i]));
    end
    check("chain.full", 32'(bus.full), 32'h1);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    check("chain.sat_cnt", 32'(dut.cnt_q), 32'h4);
    check_outs("chain.sat", 2'b00, 8'hE4, 1'b1);

    // 4. Readback: capture wins over enable.
    step(1'b1, 2'b01, 1'b0, 1'b1);
    check("rb.sr", 32'(dut.sr_q), 32'hE4);
    check_outs("rb", 2'b11, 8'hE4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      check($sformatf("rb.dout%0d", i), 32'(bus.data_out), 32'(expd[i]));
    end

    // 5. Simultaneous commit+capture swaps; then commit+enable.
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    check("sim.sr_pre", 32'(dut.sr_q), 32'h5A);
    step(1'b0, 2'b00, 1'b1, 1'b1);
    check("swap.sr", 32'(dut.sr_q), 32'hE4);
    check_outs("swap", 2'b11, 8'h5A, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    check("ce.sr", 32'(dut.sr_q), 32'h91);
    check("ce.cnt", 32'(dut.cnt_q), 32'h1);
    check_outs("ce", 2'b10, 8'hE4, 1'b0);

    // 6. Reset mid-frame.
    step(1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    nreset = 1'b0;
    step(1'b1, 2'b11, 1'b1, 1'b0);
    nreset = 1'b1;
    check_outs("rst_mid", 2'b00, 8'h00, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
    check_outs("rst_mid.3", 2'b00, 8'h00, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    check_outs("rst_mid.4", 2'b11, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
